// File: rtl/reg_pair_ctrl.sv
// reg_pair_ctrl: sequences 16-bit register-pair LOAD/INC/DEC/READ against
// an 8x8 register file, splitting each pair write into lo then hi byte.
// Ports: i_clk, i_rst (async, active-high); request i_req_valid/o_req_ready
// with i_req_op, i_req_pair, i_req_data; register-file reads o_reg_a_sel,
// o_reg_b_sel, i_reg_a, i_reg_b; write port o_reg_wr_sel/en/data;
// status o_done, o_result, o_busy.
// Optional macro REG_PAIR_FLAG_MASK_EN: clears bits [3:0] of bytes written to F.
module reg_pair_ctrl #(
  parameter logic INIT_IDLE_READY = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [1:0]  i_req_pair,
  input  logic [15:0] i_req_data,
  output logic [2:0]  o_reg_a_sel,
  output logic [2:0]  o_reg_b_sel,
  input  logic [7:0]  i_reg_a,
  input  logic [7:0]  i_reg_b,
  output logic [2:0]  o_reg_wr_sel,
  output logic        o_reg_wr_en,
  output logic [7:0]  o_reg_wr_data,
  output logic        o_done,
  output logic [15:0] o_result,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE, RD, WR_LO, WR_HI
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] PR_AF   = 2'b11;

  state_t      state;
  logic [1:0]  op_q;
  logic [1:0]  pair_q;
  logic [15:0] val_q;
  logic [15:0] rd_val;
  logic [15:0] wval;
  logic [15:0] mask;
  logic [2:0]  hi_idx;
  logic [2:0]  lo_idx;

  assign rd_val = {i_reg_a, i_reg_b};

  always_comb begin
    hi_idx = 3'd0;
    lo_idx = 3'd1;
    unique case (pair_q)
      2'b00: begin hi_idx = 3'd0; lo_idx = 3'd1; end
      2'b01: begin hi_idx = 3'd2; lo_idx = 3'd3; end
      2'b10: begin hi_idx = 3'd4; lo_idx = 3'd5; end
      2'b11: begin hi_idx = 3'd7; lo_idx = 3'd6; end
    endcase
  end

  // F is the low byte of AF; only written values pass through the mask,
  // so READ results are never affected.
  always_comb begin
    mask = 16'hFFFF;
`ifdef REG_PAIR_FLAG_MASK_EN
    if (pair_q == PR_AF)
      mask = 16'hFFF0;
`endif
  end

  assign wval = val_q & mask;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      op_q     <= 2'b00;
      pair_q   <= 2'b00;
      val_q    <= 16'h0000;
      o_done   <= 1'b0;
      o_result <= 16'h0000;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req_valid) begin
            op_q   <= i_req_op;
            pair_q <= i_req_pair;
            val_q  <= i_req_data;
            state  <= (i_req_op == OP_LOAD) ? WR_LO : RD;
          end
        end
        RD: begin
          if (op_q == OP_INC) begin
            val_q <= rd_val + 16'd1;
            state <= WR_LO;
          end else if (op_q == OP_DEC) begin
            val_q <= rd_val - 16'd1;
            state <= WR_LO;
          end else begin
            o_result <= rd_val;
            o_done   <= 1'b1;
            state    <= IDLE;
          end
        end
        WR_LO: state <= WR_HI;
        WR_HI: begin
          o_result <= wval;
          o_done   <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Write strobes decode straight from state, so an async reset
  // removes them at once.
  always_comb begin
    o_reg_wr_en   = 1'b0;
    o_reg_wr_sel  = 3'd0;
    o_reg_wr_data = 8'h00;
    unique case (1'b1)
      (state == WR_LO): begin
        o_reg_wr_en   = 1'b1;
        o_reg_wr_sel  = lo_idx;
        o_reg_wr_data = wval[7:0];
      end
      (state == WR_HI): begin
        o_reg_wr_en   = 1'b1;
        o_reg_wr_sel  = hi_idx;
        o_reg_wr_data = wval[15:8];
      end
      default: ;
    endcase
  end

  assign o_busy      = (state != IDLE);
  assign o_reg_a_sel = o_busy ? hi_idx : 3'd0;
  assign o_reg_b_sel = o_busy ? lo_idx : 3'd0;
  assign o_req_ready = i_rst ? INIT_IDLE_READY : !o_busy;

endmodule

// File: tb/tb_reg_pair_ctrl.sv
// tb_reg_pair_ctrl: directed vector bench for reg_pair_ctrl with a
// behavioural 8x8 register file attached to its ports.
module tb_reg_pair_ctrl;

  localparam logic INIT = 1'b1;
  localparam logic [1:0] LD = 2'b00, INC = 2'b01, DEC = 2'b10, RDOP = 2'b11;
  localparam logic [1:0] BC = 2'b00, DE = 2'b01, HL = 2'b10, AF = 2'b11;
`ifdef REG_PAIR_FLAG_MASK_EN
  localparam logic [7:0] FM = 8'hF0;
`else
  localparam logic [7:0] FM = 8'hFF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [1:0]  req_pair = 2'b00;
  logic [15:0] req_data = 16'h0;
  logic [2:0]  a_sel, b_sel, wr_sel;
  logic [7:0]  reg_a, reg_b, wr_data;
  logic        wr_en, done, busy;
  logic [15:0] result;

  logic [7:0]  rf [8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_sel = 3'd0;
  logic [7:0]  pre_data = 8'h0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) rf[pre_sel] <= pre_data;
    else if (wr_en) rf[wr_sel] <= wr_data;
  end

  assign reg_a = rf[a_sel];
  assign reg_b = rf[b_sel];

  reg_pair_ctrl #(.INIT_IDLE_READY(INIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_pair(req_pair), .i_req_data(req_data),
    .o_reg_a_sel(a_sel), .o_reg_b_sel(b_sel),
    .i_reg_a(reg_a), .i_reg_b(reg_b),
    .o_reg_wr_sel(wr_sel), .o_reg_wr_en(wr_en), .o_reg_wr_data(wr_data),
    .o_done(done), .o_result(result), .o_busy(busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  pair;
    logic [15:0] data;
    logic [7:0]  ihi;
    logic [7:0]  ilo;
    int          nwr;
    logic [2:0]  s1;
    logic [7:0]  d1;
    logic [2:0]  s2;
    logic [7:0]  d2;
    logic [15:0] res;
    int          lat;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] hi_of(input logic [1:0] p);
    case (p)
      2'b00: return 3'd0;
      2'b01: return 3'd2;
      2'b10: return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] lo_of(input logic [1:0] p);
    case (p)
      2'b00: return 3'd1;
      2'b01: return 3'd3;
      2'b10: return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  task automatic preload(input logic [2:0] s, input logic [7:0] d);
    pre_en = 1'b1; pre_sel = s; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int nw;
    int lat;
    logic [2:0] ws1, ws2;
    logic [7:0] wd1, wd2;
    logic [7:0] ehi, elo;
    nw = 0; lat = 0;
    ws1 = 0; ws2 = 0; wd1 = 0; wd2 = 0;
    preload(hi_of(v[i].pair), v[i].ihi);
    preload(lo_of(v[i].pair), v[i].ilo);
    chk($sformatf("v%0d ready", i), {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_op = v[i].op; req_pair = v[i].pair; req_data = v[i].data;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      #1;
      req_valid = 1'b0;
      if (wr_en) begin
        if (nw == 0) begin ws1 = wr_sel; wd1 = wr_data; end
        else begin ws2 = wr_sel; wd2 = wr_data; end
        nw++;
      end
      if (done) begin lat = c; break; end
      @(posedge clk);
    end
    chk($sformatf("v%0d latency", i), lat, v[i].lat);
    chk($sformatf("v%0d nwr", i), nw, v[i].nwr);
    if (v[i].nwr == 2) begin
      chk($sformatf("v%0d wr1", i), {ws1, wd1}, {v[i].s1, v[i].d1});
      chk($sformatf("v%0d wr2", i), {ws2, wd2}, {v[i].s2, v[i].d2});
    end
    chk($sformatf("v%0d result", i), result, v[i].res);
    ehi = (v[i].nwr == 2) ? v[i].d2 : v[i].ihi;
    elo = (v[i].nwr == 2) ? v[i].d1 : v[i].ilo;
    chk($sformatf("v%0d rf", i),
        {rf[hi_of(v[i].pair)], rf[lo_of(v[i].pair)]}, {ehi, elo});
    @(posedge clk); #1;
    chk($sformatf("v%0d done pulse", i), {31'd0, done}, 0);
  endtask

  initial begin
    v[0] = '{LD,   HL, 16'hC0DE, 8'h00, 8'h00, 2, 3'd5, 8'hDE, 3'd4, 8'hC0,
             16'hC0DE, 3};
    v[1] = '{INC,  DE, 16'h0000, 8'h12, 8'hFF, 2, 3'd3, 8'h00, 3'd2, 8'h13,
             16'h1300, 4};
    v[2] = '{DEC,  BC, 16'h0000, 8'h00, 8'h00, 2, 3'd1, 8'hFF, 3'd0, 8'hFF,
             16'hFFFF, 4};
    v[3] = '{INC,  BC, 16'h0000, 8'hFF, 8'hFF, 2, 3'd1, 8'h00, 3'd0, 8'h00,
             16'h0000, 4};
    v[4] = '{LD,   AF, 16'h12AB, 8'h00, 8'h00, 2, 3'd6, 8'hAB & FM, 3'd7,
             8'h12, {8'h12, 8'hAB & FM}, 3};
    v[5] = '{RDOP, HL, 16'h0000, 8'hBE, 8'hEF, 0, 3'd0, 8'h00, 3'd0, 8'h00,
             16'hBEEF, 2};
    v[6] = '{DEC,  AF, 16'h0000, 8'h10, 8'h00, 2, 3'd6, 8'hFF & FM, 3'd7,
             8'h0F, {8'h0F, 8'hFF & FM}, 4};
    v[7] = '{RDOP, AF, 16'h0000, 8'h12, 8'h3C, 0, 3'd0, 8'h00, 3'd0, 8'h00,
             16'h123C, 2};

    #3;
    chk("rst ready", {31'd0, req_ready}, {31'd0, INIT});
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst wr", {wr_en, wr_sel, wr_data}, 0);
    chk("rst done/result", {done, result}, 0);
    chk("rst sels", {a_sel, b_sel}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Held request during a LOAD is taken only on the done cycle.
    req_valid = 1'b1; req_op = LD; req_pair = BC; req_data = 16'h1234;
    @(posedge clk); #1;
    req_op = RDOP;
    chk("b2b ready c1", {31'd0, req_ready}, 0);
    @(posedge clk); #1;
    chk("b2b ready c2", {31'd0, req_ready}, 0);
    @(posedge clk); #1;
    chk("b2b done c3", {done, req_ready, result}, {2'b11, 16'h1234});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b rd busy", {busy, done}, 2'b10);
    @(posedge clk); #1;
    chk("b2b read", {done, result}, {1'b1, 16'h1234});
    @(posedge clk); #1;

    // Reset in the middle of WR_LO.
    preload(3'd2, 8'h77);
    preload(3'd3, 8'h88);
    req_valid = 1'b1; req_op = LD; req_pair = DE; req_data = 16'hA55A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort wr_lo", {wr_en, wr_sel, wr_data}, {1'b1, 3'd3, 8'h5A});
    #2 rst = 1'b1;
    #1;
    chk("abort wr_en", {31'd0, wr_en}, 0);
    chk("abort busy/ready", {busy, req_ready}, {1'b0, INIT});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort quiet %0d", c), {wr_en, done}, 0);
      @(posedge clk); #1;
    end
    chk("abort idle", {busy, req_ready, result}, {2'b01, 16'h0000});
    chk("abort rf", {rf[2], rf[3]}, 16'h7788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_pair_ctrl.md
Name: reg_pair_ctrl

Overview:
- Sequencer that runs 16-bit register-pair operations (LD rr,d16; INC rr; DEC rr; pair read) against the CPU's 8x8-bit register file.
- Drives the register file's 3-bit read selects (a, b) and its single 8-bit write port.
- Splits every 16-bit pair write into two byte writes on consecutive cycles.
- Sits between the CPU decode/control FSM and the register file.
- Request side uses a valid/ready handshake; completion is a one-cycle done pulse.

Parameters:
- INIT_IDLE_READY, 1, value of o_req_ready while i_rst is asserted (1 = ready, 0 = not ready).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_req_valid  input  1  request strobe
- o_req_ready  output  1  controller can accept a request
- i_req_op  input  2  00 LOAD, 01 INC, 10 DEC, 11 READ
- i_req_pair  input  2  00 BC, 01 DE, 10 HL, 11 AF
- i_req_data  input  16  LOAD operand, {hi,lo}
- o_reg_a_sel  output  3  register-file read select, high byte
- o_reg_b_sel  output  3  register-file read select, low byte
- i_reg_a  input  8  register-file read data a
- i_reg_b  input  8  register-file read data b
- o_reg_wr_sel  output  3  write select
- o_reg_wr_en  output  1  write enable
- o_reg_wr_data  output  8  write data
- o_done  output  1  one-cycle completion pulse
- o_result  output  16  pair value after the operation (READ: value read)
- o_busy  output  1  state != IDLE

Behaviour:
- Register index map: B=0, C=1, D=2, E=3, H=4, L=5, F=6, A=7.
- Pair to (hi,lo) index: BC=(0,1), DE=(2,3), HL=(4,5), AF=(7,6).
- Read selects are driven combinationally from the latched pair in every state; they are 0 in IDLE.
- Read data is consumed in the same cycle it is selected (register-file reads are combinational).
- States: IDLE, RD, WR_LO, WR_HI.
- IDLE: o_req_ready=1. On i_req_valid, latch op, pair and data; the handshake completes in that cycle.
  - LOAD: result := i_req_data, go to WR_LO.
  - INC, DEC, READ: go to RD.
- RD: capture {i_reg_a,i_reg_b}.
  - INC: result := value+1 mod 2^16 (0xFFFF -> 0x0000).
  - DEC: result := value-1 mod 2^16 (0x0000 -> 0xFFFF).
  - INC or DEC: go to WR_LO.
  - READ: result := value, go to IDLE, assert o_done in the next cycle.
- WR_LO: o_reg_wr_en=1, o_reg_wr_sel=lo index, o_reg_wr_data=result[7:0]. Go to WR_HI.
- WR_HI: o_reg_wr_en=1, o_reg_wr_sel=hi index, o_reg_wr_data=result[15:8]. Go to IDLE.
- o_done: registered; high for exactly one cycle, the first IDLE cycle after WR_HI (or after RD for READ). Both bytes are committed in the register file by then.
- o_result: registered; updated together with o_done and held until the next completion.
- Latency from accept cycle to o_done: LOAD 3 cycles; INC/DEC 4 cycles; READ 2 cycles.
- Back-to-back: a request may be accepted in the same cycle o_done is high. o_req_ready=0 in every non-IDLE state; i_req_valid is ignored there and the requester must hold it.
- o_reg_wr_en=0 in IDLE and RD. Never more than one write per cycle.
- Reset values: state IDLE, o_reg_wr_en=0, o_reg_wr_sel=0, o_reg_wr_data=0, o_done=0, o_result=0, o_busy=0, selects=0, latched fields=0, o_req_ready=INIT_IDLE_READY.
- Reset mid-operation: abort immediately; no further writes (a completed WR_LO may leave the pair half-written, which is accepted); no o_done.
- Unused register-file port c is not driven by this block.

Optional Feature:
- Macro REG_PAIR_FLAG_MASK_EN.
- Defined: any byte written to F (index 6) has bits [3:0] forced to 0, and o_result reflects the masked value. Applies to LOAD/INC/DEC of AF.
- Undefined: F is written unmodified.
- READ is never masked.

Test Plan:
- LOAD HL=0xC0DE -> wr (5,0xDE) in the cycle after accept, then (4,0xC0); o_done 3 cycles after accept; o_result=0xC0DE.
- INC DE with D=0x12, E=0xFF -> writes (3,0x00) then (2,0x13); o_result=0x1300.
- DEC BC with B=0x00, C=0x00 -> writes (1,0xFF) then (0,0xFF); o_result=0xFFFF. INC of 0xFFFF -> 0x0000.
- LOAD AF=0x12AB -> macro defined: F=0xA0, o_result=0x12A0. Macro undefined: F=0xAB. A=0x12 in both cases.
- READ HL=0xBEEF -> no write strobes; o_done 2 cycles after accept with o_result=0xBEEF. A request held valid during busy is accepted only on the o_done cycle.
- Assert i_rst during WR_LO of a LOAD -> o_reg_wr_en drops asynchronously, no WR_HI write, no o_done; after release o_busy=0 and o_req_ready=INIT_IDLE_READY during reset, 1 after release.
